// File: rtl/sound_glu_pkg.sv
// Shared types, register map and saturation helper for the IIgs sound GLU.
package sound_glu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_WR = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_DOC_RD = 2'd3
    } glu_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_PTR_LO = 2'd2;
    localparam logic [1:0] REG_PTR_HI = 2'd3;

    localparam int CTRL_BUSY    = 7;
    localparam int CTRL_RAM     = 6;
    localparam int CTRL_AUTOINC = 5;
    localparam int CTRL_VOL_HI  = 3;
    localparam int CTRL_VOL_LO  = 0;

    localparam logic [6:0] CTRL_RESET = 7'h0F;

    function automatic logic signed [15:0] sat16(input logic signed [20:0] v);
        logic signed [15:0] r;
        if (v > 21'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -21'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/glu_volume_scaler.sv
// Per-channel master-volume scaling: sat16((sample * (vol+1)) >>> 4), one-cycle latency.
module glu_volume_scaler
    import sound_glu_pkg::*;
#(
    parameter int CHANNELS = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [3:0]              vol_i,
    input  logic [16*CHANNELS-1:0]  audio_i,
    output logic [16*CHANNELS-1:0]  audio_o
);

    logic signed [20:0]        gain_s;
    logic [16*CHANNELS-1:0]    scaled_s;

    assign gain_s = $signed({17'd0, vol_i}) + 21'sd1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [20:0] sample_s;
        logic signed [20:0] prod_s;
        logic signed [20:0] shifted_s;

        assign sample_s  = 21'($signed(audio_i[16*c +: 16]));
        assign prod_s    = sample_s * gain_s;
        assign shifted_s = prod_s >>> 4;
        assign scaled_s[16*c +: 16] = sat16(shifted_s);
    end

    // Output register for the scaled samples.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            audio_o <= '0;
        end else begin
            audio_o <= scaled_s;
        end
    end

endmodule

// File: rtl/sound_glu_dma.sv
// Second-generation GLU: register decode, one-behind RAM/DOC data port, overrun flag, volume.
module sound_glu_dma
    import sound_glu_pkg::*;
#(
    parameter int                    ADDR_W     = 16,
    parameter int                    WORD_BYTES = 4,
    parameter int                    MEM_ADDR_W = 21,
    parameter logic [MEM_ADDR_W-1:0] MEM_BASE   = 21'h1_0000,
    parameter int                    CHANNELS   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     sel_i,
    input  logic [1:0]               reg_i,
    input  logic                     we_i,
    input  logic                     strobe_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic                     doc_cs_n_o,
    output logic                     doc_we_n_o,
    output logic [7:0]               doc_addr_o,
    output logic [7:0]               doc_data_o,
    input  logic [7:0]               doc_data_i,
    output logic                     mem_rd_o,
    output logic                     mem_wr_o,
    output logic [MEM_ADDR_W-1:0]    mem_addr_o,
    output logic [WORD_BYTES-1:0]    mem_byte_en_o,
    output logic [8*WORD_BYTES-1:0]  mem_data_o,
    input  logic [8*WORD_BYTES-1:0]  mem_q_i,
    input  logic                     mem_ready_i,
    input  logic [16*CHANNELS-1:0]   audio_i,
    output logic [16*CHANNELS-1:0]   audio_o,
    output logic                     overrun_o
);

    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SHIFT  = $clog2(WORD_BYTES);
    localparam int PW     = (ADDR_W > 16) ? ADDR_W : 16;

    glu_state_e              state_r;
    logic [6:0]              ctrl_r;
    logic [7:0]              data_r;
    logic [ADDR_W-1:0]       ptr_r;
    logic [MEM_ADDR_W-1:0]   mem_addr_r;
    logic [LANE_W-1:0]       lane_r;
    logic [WORD_BYTES-1:0]   byte_en_r;
    logic                    mem_rd_r;
    logic                    mem_wr_r;
    logic                    doc_cs_n_r;
    logic                    doc_we_n_r;
    logic [7:0]              doc_addr_r;
    logic [7:0]              doc_data_r;
    logic                    doc_phase_r;
    logic                    overrun_r;

    logic                    busy_s;
    logic                    bus_wr_s;
    logic                    data_acc_s;
    logic                    accept_s;
    logic [15:0]             ptr_view_s;
    logic [PW-1:0]           ptr_wide_s;
    logic [ADDR_W-1:0]       ptr_next_s;
    logic [LANE_W-1:0]       lane_now_s;
    logic [MEM_ADDR_W-1:0]   word_now_s;
    logic [7:0]              q_byte_s;

    assign busy_s     = (state_r != ST_IDLE);
    assign bus_wr_s   = sel_i & strobe_i & we_i;
    assign data_acc_s = sel_i & strobe_i & (reg_i == REG_DATA);
    assign accept_s   = data_acc_s & ~busy_s;
    assign ptr_view_s = 16'(ptr_r);
    assign lane_now_s = LANE_W'(ptr_r % ADDR_W'(WORD_BYTES));
    assign word_now_s = MEM_BASE + MEM_ADDR_W'(ptr_r >> SHIFT);

    // Next pointer: bus byte writes take priority, else post-increment on accepted data access.
    always_comb begin
        ptr_wide_s = PW'(ptr_r);
        if (bus_wr_s && (reg_i == REG_PTR_LO)) begin
            ptr_wide_s[7:0] = data_i;
        end else if (bus_wr_s && (reg_i == REG_PTR_HI)) begin
            ptr_wide_s[15:8] = data_i;
        end else if (accept_s && ctrl_r[CTRL_AUTOINC]) begin
            ptr_wide_s = PW'(ptr_r + ADDR_W'(1));
        end else begin
            ptr_wide_s = PW'(ptr_r);
        end
        ptr_next_s = ADDR_W'(ptr_wide_s);
    end

    // Select the addressed byte lane of the returned memory word.
    always_comb begin
        q_byte_s = 8'h00;
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (lane_r == LANE_W'(l)) begin
                q_byte_s = mem_q_i[8*l +: 8];
            end else begin
                q_byte_s = q_byte_s;
            end
        end
    end

    // Register read mux; the data register always returns the previously fetched byte.
    always_comb begin
        case (reg_i)
            REG_CTRL:   data_o = {busy_s, ctrl_r};
            REG_DATA:   data_o = data_r;
            REG_PTR_LO: data_o = ptr_view_s[7:0];
            REG_PTR_HI: data_o = ptr_view_s[15:8];
            default:    data_o = 8'h00;
        endcase
    end

    // Register file and transfer FSM with registered bus/memory strobes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            ctrl_r      <= CTRL_RESET;
            data_r      <= 8'h00;
            ptr_r       <= '0;
            mem_addr_r  <= '0;
            lane_r      <= '0;
            byte_en_r   <= '0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            doc_cs_n_r  <= 1'b1;
            doc_we_n_r  <= 1'b1;
            doc_addr_r  <= 8'h00;
            doc_data_r  <= 8'h00;
            doc_phase_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            doc_cs_n_r <= 1'b1;
            doc_we_n_r <= 1'b1;
            ptr_r      <= ptr_next_s;

            if (bus_wr_s && (reg_i == REG_CTRL)) begin
                ctrl_r    <= data_i[6:0];
                overrun_r <= 1'b0;
            end else if (data_acc_s && busy_s) begin
                overrun_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mem_addr_r <= word_now_s;
                        lane_r     <= lane_now_s;
                        byte_en_r  <= WORD_BYTES'(1) << lane_now_s;
                        doc_addr_r <= ptr_view_s[7:0];
                        if (we_i) begin
                            data_r     <= data_i;
                            doc_data_r <= data_i;
                            if (ctrl_r[CTRL_RAM]) begin
                                mem_wr_r <= 1'b1;
                                state_r  <= ST_MEM_WR;
                            end else begin
                                doc_cs_n_r <= 1'b0;
                                doc_we_n_r <= 1'b0;
                            end
                        end else if (ctrl_r[CTRL_RAM]) begin
                            mem_rd_r <= 1'b1;
                            state_r  <= ST_MEM_RD;
                        end else begin
                            doc_cs_n_r  <= 1'b0;
                            doc_phase_r <= 1'b0;
                            state_r     <= ST_DOC_RD;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready_i) begin
                        mem_wr_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready_i) begin
                        mem_rd_r <= 1'b0;
                        data_r   <= q_byte_s;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_DOC_RD: begin
                    // DOC data is valid the cycle after the chip-select pulse.
                    if (doc_phase_r) begin
                        data_r  <= doc_data_i;
                        state_r <= ST_IDLE;
                    end else begin
                        doc_phase_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign doc_cs_n_o    = doc_cs_n_r;
    assign doc_we_n_o    = doc_we_n_r;
    assign doc_addr_o    = doc_addr_r;
    assign doc_data_o    = doc_data_r;
    assign mem_rd_o      = mem_rd_r;
    assign mem_wr_o      = mem_wr_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_byte_en_o = byte_en_r;
    assign mem_data_o    = {WORD_BYTES{data_r}};
    assign overrun_o     = overrun_r;

    glu_volume_scaler #(
        .CHANNELS (CHANNELS)
    ) u_scaler (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .vol_i   (ctrl_r[CTRL_VOL_HI:CTRL_VOL_LO]),
        .audio_i (audio_i),
        .audio_o (audio_o)
    );

endmodule

// File: tb/tb_sound_glu_dma.sv
// Directed plus randomized bench for sound_glu_dma against a register-level behavioural model.
module tb_sound_glu_dma;

    logic        clk;
    logic        reset_i;
    logic        sel_i;
    logic [1:0]  reg_i;
    logic        we_i;
    logic        strobe_i;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        doc_cs_n_o;
    logic        doc_we_n_o;
    logic [7:0]  doc_addr_o;
    logic [7:0]  doc_data_o;
    logic [7:0]  doc_data_i;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [20:0] mem_addr_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_q_i;
    logic        mem_ready_i;
    logic [31:0] audio_i;
    logic [31:0] audio_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [6:0]  m_ctrl;
    logic [15:0] m_ptr;
    logic [7:0]  m_data;
    logic        m_ovr;
    logic [7:0]  ram[int];
    logic [7:0]  exp_ram[int];

    sound_glu_dma dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .sel_i         (sel_i),
        .reg_i         (reg_i),
        .we_i          (we_i),
        .strobe_i      (strobe_i),
        .data_i        (data_i),
        .data_o        (data_o),
        .doc_cs_n_o    (doc_cs_n_o),
        .doc_we_n_o    (doc_we_n_o),
        .doc_addr_o    (doc_addr_o),
        .doc_data_o    (doc_data_o),
        .doc_data_i    (doc_data_i),
        .mem_rd_o      (mem_rd_o),
        .mem_wr_o      (mem_wr_o),
        .mem_addr_o    (mem_addr_o),
        .mem_byte_en_o (mem_byte_en_o),
        .mem_data_o    (mem_data_o),
        .mem_q_i       (mem_q_i),
        .mem_ready_i   (mem_ready_i),
        .audio_i       (audio_i),
        .audio_o       (audio_o),
        .overrun_o     (overrun_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fill(input int k);
        return 8'(k * 37 + 11);
    endfunction

    function automatic int key(input logic [15:0] p);
        return (32'h1_0000 + int'(p >> 2)) * 4 + int'(p % 16'd4);
    endfunction

    function automatic logic [7:0] ram_byte(input int k);
        return ram.exists(k) ? ram[k] : fill(k);
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        return exp_ram.exists(k) ? exp_ram[k] : fill(k);
    endfunction

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] v);
        int p;
        p = ($signed(s) * (int'(v) + 1)) >>> 4;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return 16'(p);
    endfunction

    task automatic peek(input logic [1:0] r, output logic [7:0] q);
        sel_i = 1'b1; strobe_i = 1'b0; we_i = 1'b0; reg_i = r;
        #1;
        q = data_o;
    endtask

    task automatic bus_op(input logic w, input logic [1:0] r, input logic [7:0] d, output logic [7:0] q);
        sel_i = 1'b1; strobe_i = 1'b1; we_i = w; reg_i = r; data_i = d;
        #1;
        q = data_o;
        @(negedge clk);
        strobe_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_ctrl(input logic [7:0] d);
        logic [7:0] q;
        bus_op(1'b1, 2'd0, d, q);
        m_ctrl = d[6:0];
        m_ovr  = 1'b0;
    endtask

    task automatic do_ptr(input logic [15:0] p);
        logic [7:0] q;
        bus_op(1'b1, 2'd2, p[7:0], q);
        bus_op(1'b1, 2'd3, p[15:8], q);
        m_ptr = p;
    endtask

    // Memory responder: waits for a request, checks it, answers with a ready pulse.
    task automatic serve(input bit is_wr, input logic [15:0] p, input logic [7:0] d);
        int n = 0;
        while (!(mem_wr_o || mem_rd_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_latency", n, 0);
        chk("mem_req_kind", {mem_wr_o, mem_rd_o}, is_wr ? 2'b10 : 2'b01);
        chk("mem_addr", mem_addr_o, 21'h1_0000 + 21'(p >> 2));
        chk("mem_byte_en", mem_byte_en_o, 4'b0001 << p[1:0]);
        if (is_wr) chk("mem_wdata", mem_data_o, {4{d}});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            mem_q_i[8*l +: 8] = ram_byte(int'(mem_addr_o) * 4 + l);
            if (is_wr && mem_byte_en_o[l]) ram[int'(mem_addr_o) * 4 + l] = mem_data_o[8*l +: 8];
        end
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        mem_q_i = $urandom;
        chk("mem_req_drop", {mem_wr_o, mem_rd_o}, 2'b00);
    endtask

    task automatic advance();
        if (m_ctrl[5]) m_ptr = m_ptr + 16'd1;
    endtask

    task automatic do_write(input logic [7:0] d);
        logic [7:0]  q;
        logic [15:0] p;
        p = m_ptr;
        bus_op(1'b1, 2'd1, d, q);
        m_data = d;
        if (m_ctrl[6]) begin
            serve(1'b1, p, d);
            exp_ram[key(p)] = d;
        end else begin
            chk("doc_wr_cs", doc_cs_n_o, 1'b0);
            chk("doc_wr_we", doc_we_n_o, 1'b0);
            chk("doc_wr_addr", doc_addr_o, p[7:0]);
            chk("doc_wr_data", doc_data_o, d);
            @(negedge clk);
            chk("doc_wr_cs_end", doc_cs_n_o, 1'b1);
        end
        advance();
    endtask

    task automatic do_read();
        logic [7:0]  q;
        logic [15:0] p;
        int n;
        p = m_ptr;
        if (!m_ctrl[6]) doc_data_i = $urandom;
        bus_op(1'b0, 2'd1, 8'h00, q);
        chk("data_rd_stale", q, m_data);
        if (m_ctrl[6]) begin
            serve(1'b0, p, 8'h00);
            m_data = exp_byte(key(p));
        end else begin
            chk("doc_rd_cs", doc_cs_n_o, 1'b0);
            chk("doc_rd_we", doc_we_n_o, 1'b1);
            chk("doc_rd_addr", doc_addr_o, p[7:0]);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                peek(2'd0, q);
            end while (q[7] && n < 10);
            chk("doc_rd_cycles", n, 2);
            m_data = doc_data_i;
        end
        advance();
    endtask

    task automatic check_state();
        logic [7:0] lo, hi, q;
        peek(2'd2, lo);
        peek(2'd3, hi);
        chk("ptr", {hi, lo}, m_ptr);
        peek(2'd1, q);
        chk("data_reg", q, m_data);
        peek(2'd0, q);
        chk("ctrl_reg", q, {1'b0, m_ctrl});
        chk("overrun", overrun_o, m_ovr);
    endtask

    initial begin
        logic [7:0]  q;
        logic [15:0] p;
        logic [3:0]  v;
        reset_i = 1'b1; sel_i = 1'b0; reg_i = 2'd0; we_i = 1'b0; strobe_i = 1'b0;
        data_i = 8'h00; doc_data_i = 8'h00; mem_q_i = 32'h0; mem_ready_i = 1'b0; audio_i = 32'h0;
        m_ctrl = 7'h0F; m_ptr = 16'h0000; m_data = 8'h00; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;

        // Reset state
        chk("rst_mem_rd", mem_rd_o, 1'b0);
        chk("rst_mem_wr", mem_wr_o, 1'b0);
        chk("rst_doc_cs", doc_cs_n_o, 1'b1);
        chk("rst_doc_we", doc_we_n_o, 1'b1);
        chk("rst_audio", audio_o, 32'h0);
        check_state();

        // RAM write with auto-increment at 0x0105
        @(negedge clk);
        do_ctrl(8'h6F);
        do_ptr(16'h0105);
        p = m_ptr;
        bus_op(1'b1, 2'd1, 8'hA5, q);
        peek(2'd0, q);
        chk("busy_during_wr", q, {1'b1, m_ctrl});
        serve(1'b1, p, 8'hA5);
        exp_ram[key(p)] = 8'hA5;
        m_data = 8'hA5;
        advance();
        @(negedge clk);
        check_state();

        // One-behind RAM reads at 0x0200
        do_ptr(16'h0200);
        for (int l = 0; l < 4; l++) begin
            ram[key(16'h0200) + l]     = 8'(8'h11 * (l + 1));
            exp_ram[key(16'h0200) + l] = 8'(8'h11 * (l + 1));
        end
        do_read();
        @(negedge clk);
        do_read();
        @(negedge clk);
        check_state();

        // Data write while busy is dropped and flags overrun
        p = m_ptr;
        bus_op(1'b1, 2'd1, 8'h3C, q);
        bus_op(1'b1, 2'd1, 8'hC3, q);
        m_data = 8'h3C;
        advance();
        m_ovr = 1'b1;
        chk("overrun_set", overrun_o, 1'b1);
        serve(1'b1, p, 8'h3C);
        exp_ram[key(p)] = 8'h3C;
        @(negedge clk);
        check_state();
        do_ctrl(8'h6F);
        @(negedge clk);
        check_state();

        // DOC write wraps the pointer from 0xFFFF
        do_ctrl(8'h2F);
        do_ptr(16'hFFFF);
        do_write(8'h5A);
        @(negedge clk);
        check_state();
        do_read();
        @(negedge clk);
        check_state();

        // Volume boundaries
        do_ctrl(8'h0F);
        audio_i = {16'h8000, 16'h7FFF};
        @(negedge clk);
        chk("audio_vol15", audio_o, {16'h8000, 16'h7FFF});
        do_ctrl(8'h07);
        @(negedge clk);
        chk("audio_vol7", audio_o, {16'hC000, 16'h3FFF});

        // Randomized volume scaling
        for (int i = 0; i < 16; i++) begin
            v = 4'($urandom_range(0, 15));
            do_ctrl({4'b0000, v});
            audio_i = $urandom;
            @(negedge clk);
            chk("audio_rand", audio_o, {scale(audio_i[31:16], v), scale(audio_i[15:0], v)});
        end

        // Randomized register traffic in both RAM and DOC modes
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0:       do_ctrl(8'($urandom) & 8'h6F | 8'h40 * 8'($urandom_range(0, 1)));
                1:       do_ptr(16'($urandom_range(0, 24)) | (($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h0000));
                2, 3:    do_write(8'($urandom));
                default: do_read();
            endcase
            @(negedge clk);
            check_state();
        end

        // Reset in the middle of a RAM write; a late ready must be ignored
        do_ctrl(8'h6F);
        do_ptr(16'h0010);
        bus_op(1'b1, 2'd1, 8'h77, q);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        m_ctrl = 7'h0F; m_ptr = 16'h0000; m_data = 8'h00; m_ovr = 1'b0;
        chk("rst_mid_wr", mem_wr_o, 1'b0);
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        chk("rst_late_ready", {mem_wr_o, mem_rd_o}, 2'b00);
        check_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
